race_mac_sequencer: RTL and testbench
=====================================

Name: race_mac_sequencer

Overview:
Sequences one shared MAC (multiplier + non-clearing accumulator, 2-stage: mult register, then acc register) to compute one TAPS-tap FIR output per accepted input sample.
- Owns the circular sample delay line.
- Drives the coefficient read address and MAC operands.
- The MAC accumulator has no clear, so the block derives each output as the difference between the accumulator after and before the burst.
- Sits between the sample source and the adaptive-filter output/error stage.

Parameters:
SAMPLE_SIZE, 16, sample width (signed)
COEFF_SIZE, 17, coefficient width (signed)
TAPS, 32, filter length, >= 2
FRAC_SHIFT, 16, right-shift applied to the result when the saturation feature is compiled in

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset; must be the same net that resets the MAC
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  SAMPLE_SIZE  input sample
coeff_addr  out  clog2(TAPS)  coefficient index k; external read is combinational
coeff_data  in  COEFF_SIZE  coefficient for coeff_addr, same cycle
mac_en  out  1  MAC enable
mac_s  out  SAMPLE_SIZE  MAC sample operand
mac_c  out  COEFF_SIZE  MAC coefficient operand (= coeff_data)
mac_dout  in  SAMPLE_SIZE+COEFF_SIZE  MAC accumulator
y_valid  out  1  one-cycle result strobe
y_data  out  YW  result; YW = SAMPLE_SIZE+COEFF_SIZE, or SAMPLE_SIZE with the feature compiled in

Behaviour:
- Reset: all outputs 0, s_ready=0. State IDLE; wp=0; delay line all zero; acc_prev=0, matching the MAC acc reset. s_ready rises in the first cycle after release.
- FSM:
  - IDLE: s_ready=1. On s_valid at a clock edge (cycle 0): write s_data to line[wp], go to RUN, k=0.
  - RUN, cycles 1..TAPS: mac_en=1, coeff_addr=k, mac_s=line[(wp-k) mod TAPS], k increments each cycle. After k=TAPS-1, go to DRAIN.
  - DRAIN, cycles TAPS+1 and TAPS+2: mac_en=0. This covers the MAC pipeline (mult, then the registered acc_en update). At the end of cycle TAPS+2: y_reg <= mac_dout - acc_prev (modulo 2^(SAMPLE_SIZE+COEFF_SIZE)), acc_prev <= mac_dout, wp <= (wp+1) mod TAPS. Go to DONE.
  - DONE, cycle TAPS+3: y_valid=1, y_data valid. Go to IDLE.
- s_ready is 0 in every state except IDLE. A sample presented outside IDLE is held off, not dropped.
- Latency: accept edge to y_valid = TAPS+3 cycles. Throughput: one sample per TAPS+4 cycles.
- y_data holds its last value until the next DONE. No output backpressure.
- mac_s and mac_c are don't-care when mac_en=0; drive them 0.
- Accumulator wrap-around is benign because the difference is taken modulo the accumulator width. Per-output sum must fit SAMPLE_SIZE+COEFF_SIZE bits (signed).
- Wrap: the pointer indexes wrap modulo TAPS. TAPS need not be a power of 2; use explicit compare, not bit truncation.
- Reset mid-operation: immediate return to IDLE, delay line and acc_prev cleared. The MAC clears on the same nrst, so the difference stays consistent.

Optional Feature:
RACE_SEQ_SAT_EN
- Defined: y_data = full difference arithmetically shifted right by FRAC_SHIFT (truncation), then saturated to a signed SAMPLE_SIZE range (+max/-min clamps). The sat_flag register is set in DONE on clamp and cleared on the next DONE without clamp. It is internal and observable by hierarchy.
- Undefined: y_data is the full-width signed difference, with no shift or saturation.

Decomposition:
- Package race_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - MAC_LAT=2 constant
  - a clog2 helper
  - widths derived from SAMPLE_SIZE/COEFF_SIZE
- One natural sub-module, race_delay_line: a circular register array with a write port and one combinational read port at (wp-k) mod TAPS. The FSM and difference logic stay in the top.

Test Plan:
- Impulse: TAPS=4, coeffs [1,2,3,4], samples 1,0,0,0 -> y_data 1,2,3,4, each y_valid exactly 7 cycles after its accept edge.
- Step with negatives: coeffs [-1,2,-3,4], samples 5,5,5,5 -> y_data -5,5,-10,10.
- Backpressure: s_valid held high continuously -> accepts spaced exactly 8 cycles apart (TAPS=4), no sample lost; s_ready=0 throughout RUN/DRAIN/DONE.
- Accumulator wrap: many full-scale products (0x7FFF * 0x0FFFF) until mac_dout wraps -> every y_data equals the golden per-sample sum.
- Mid-burst reset: nrst low during RUN k=2, then 1,0,0,0 re-sent -> outputs 1,2,3,4 with no contamination from the aborted sample.
- With RACE_SEQ_SAT_EN, FRAC_SHIFT=0, product 40000 -> y_data=32767 and sat_flag=1; next result 10 -> y_data=10, sat_flag=0.

Source files
------------

// File: rtl/race_pkg.sv
// Shared types, constants and helpers for the MAC sequencer.
package race_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } race_state_e;

    // Cycles from the last MAC enable until the accumulator has absorbed it.
    localparam int unsigned MAC_LAT = 2;

    localparam int unsigned DEF_SAMPLE_SIZE = 16;
    localparam int unsigned DEF_COEFF_SIZE  = 17;

    // Index width for a table of 'value' entries (at least one bit).
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

    // Full product / accumulator width.
    function automatic int unsigned acc_width_f(input int unsigned sample_w,
                                                input int unsigned coeff_w);
        return sample_w + coeff_w;
    endfunction

endpackage

// File: rtl/race_delay_line.sv
// Circular sample delay line: one write port at wp, one combinational
// read port at (wp - k) mod DEPTH. DEPTH need not be a power of two.
module race_delay_line
    import race_pkg::*;
#(
    parameter  int unsigned DW    = 16,
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = clog2_f(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we_i,
    input  logic [AW-1:0] wp_i,
    input  logic [AW-1:0] k_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   idx_c;

    // Sample storage, cleared on reset so old history never leaks into a new run.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wp_i] <= wr_data_i;
        end
    end

    // Backwards tap index with explicit wrap instead of bit truncation.
    always_comb begin
        if (wp_i >= k_i) begin
            idx_c = {1'b0, wp_i} - {1'b0, k_i};
        end else begin
            idx_c = {1'b0, wp_i} + (AW+1)'(DEPTH) - {1'b0, k_i};
        end
        rd_data_o = mem_q[idx_c[AW-1:0]];
    end

endmodule

// File: rtl/race_mac_sequencer.sv
// Sequences a shared 2-stage MAC (no accumulator clear) to produce one
// TAPS-tap FIR output per accepted sample. Each result is the accumulator
// delta across the burst, taken modulo the accumulator width.
// Optional build macro RACE_SEQ_SAT_EN: result is shifted right by
// FRAC_SHIFT and saturated to SAMPLE_SIZE bits; sat_flag_q records clamps.
module race_mac_sequencer
    import race_pkg::*;
#(
    parameter  int unsigned SAMPLE_SIZE = DEF_SAMPLE_SIZE,
    parameter  int unsigned COEFF_SIZE  = DEF_COEFF_SIZE,
    parameter  int unsigned TAPS        = 32,
    parameter  int unsigned FRAC_SHIFT  = 16,
    localparam int unsigned AW          = clog2_f(TAPS),
    localparam int unsigned ACC_W       = acc_width_f(SAMPLE_SIZE, COEFF_SIZE),
`ifdef RACE_SEQ_SAT_EN
    localparam int unsigned YW          = SAMPLE_SIZE
`else
    localparam int unsigned YW          = ACC_W
`endif
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [SAMPLE_SIZE-1:0] s_data,
    output logic [AW-1:0]          coeff_addr,
    input  logic [COEFF_SIZE-1:0]  coeff_data,
    output logic                   mac_en,
    output logic [SAMPLE_SIZE-1:0] mac_s,
    output logic [COEFF_SIZE-1:0]  mac_c,
    input  logic [ACC_W-1:0]       mac_dout,
    output logic                   y_valid,
    output logic [YW-1:0]          y_data
);

    // A shift that discards the whole accumulator is a configuration mistake.
    if (FRAC_SHIFT >= ACC_W) begin : g_frac_shift_range
        $error("race_mac_sequencer: FRAC_SHIFT must be smaller than SAMPLE_SIZE+COEFF_SIZE");
    end

    race_state_e      state_q, state_d;
    logic [AW-1:0]    k_q, k_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [ACC_W-1:0] acc_prev_q, acc_prev_d;
    logic [ACC_W-1:0] diff_c;
    logic [YW-1:0]    y_q, y_d, y_next_c;
    logic             s_ready_q, mac_en_q, y_valid_q;
    logic             we_c;
    logic [SAMPLE_SIZE-1:0] rd_data_c;

`ifdef RACE_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-SAMPLE_SIZE+1){1'b0}}, {(SAMPLE_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W-SAMPLE_SIZE+1){1'b1}}, {(SAMPLE_SIZE-1){1'b0}}};

    logic                    sat_flag_q, sat_flag_d;
    logic                    clamp_c;
    logic signed [ACC_W-1:0] shifted_c;
`endif

    race_delay_line #(
        .DW    (SAMPLE_SIZE),
        .DEPTH (TAPS)
    ) u_line (
        .clk       (clk),
        .nrst      (nrst),
        .we_i      (we_c),
        .wp_i      (wp_q),
        .k_i       (k_q),
        .wr_data_i (s_data),
        .rd_data_o (rd_data_c)
    );

    // Burst result: accumulator delta, optionally rescaled and clamped.
    always_comb begin
        diff_c = mac_dout - acc_prev_q;
`ifdef RACE_SEQ_SAT_EN
        shifted_c = $signed(diff_c) >>> FRAC_SHIFT;
        clamp_c   = 1'b0;
        y_next_c  = shifted_c[YW-1:0];
        if (shifted_c > Y_MAX) begin
            y_next_c = Y_MAX[YW-1:0];
            clamp_c  = 1'b1;
        end else if (shifted_c < Y_MIN) begin
            y_next_c = Y_MIN[YW-1:0];
            clamp_c  = 1'b1;
        end
`else
        y_next_c = diff_c;
`endif
    end

    // Next-state logic; k doubles as the tap index in RUN and the drain counter.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wp_d       = wp_q;
        acc_prev_d = acc_prev_q;
        y_d        = y_q;
        we_c       = 1'b0;
`ifdef RACE_SEQ_SAT_EN
        sat_flag_d = sat_flag_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    we_c    = 1'b1;
                    state_d = RUN;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (k_q == AW'(TAPS - 1)) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            DRAIN: begin
                if (k_q == AW'(MAC_LAT - 1)) begin
                    state_d    = DONE;
                    k_d        = '0;
                    y_d        = y_next_c;
                    acc_prev_d = mac_dout;
                    wp_d       = (wp_q == AW'(TAPS - 1)) ? '0 : wp_q + AW'(1);
`ifdef RACE_SEQ_SAT_EN
                    sat_flag_d = clamp_c;
`endif
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake/strobe outputs follow next state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            wp_q       <= '0;
            acc_prev_q <= '0;
            y_q        <= '0;
            s_ready_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            y_valid_q  <= 1'b0;
`ifdef RACE_SEQ_SAT_EN
            sat_flag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wp_q       <= wp_d;
            acc_prev_q <= acc_prev_d;
            y_q        <= y_d;
            s_ready_q  <= (state_d == IDLE);
            mac_en_q   <= (state_d == RUN);
            y_valid_q  <= (state_d == DONE);
`ifdef RACE_SEQ_SAT_EN
            sat_flag_q <= sat_flag_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign mac_en     = mac_en_q;
    assign coeff_addr = k_q;
    assign mac_s      = mac_en_q ? rd_data_c : '0;
    assign mac_c      = mac_en_q ? coeff_data : '0;
    assign y_valid    = y_valid_q;
    assign y_data     = y_q;

endmodule

// File: tb/tb_race_mac_sequencer.sv
// Bench for race_mac_sequencer (TAPS=4) with a behavioural MAC, a coefficient
// ROM and a history-based FIR reference model.
module tb_race_mac_sequencer;

    localparam int TAPS  = 4;
    localparam int SS    = 16;
    localparam int CS    = 17;
    localparam int ACC_W = SS + CS;
`ifdef RACE_SEQ_SAT_EN
    localparam int YW = SS;
    localparam int FS = 0;
`else
    localparam int YW = ACC_W;
    localparam int FS = 16;
`endif

    logic             clk = 1'b0;
    logic             nrst;
    logic             s_valid;
    logic             s_ready;
    logic [SS-1:0]    s_data;
    logic [1:0]       coeff_addr;
    logic [CS-1:0]    coeff_data;
    logic             mac_en;
    logic [SS-1:0]    mac_s;
    logic [CS-1:0]    mac_c;
    logic [ACC_W-1:0] mac_dout;
    logic             y_valid;
    logic [YW-1:0]    y_data;

    race_mac_sequencer #(
        .SAMPLE_SIZE (SS),
        .COEFF_SIZE  (CS),
        .TAPS        (TAPS),
        .FRAC_SHIFT  (FS)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .mac_en     (mac_en),
        .mac_s      (mac_s),
        .mac_c      (mac_c),
        .mac_dout   (mac_dout),
        .y_valid    (y_valid),
        .y_data     (y_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient ROM with combinational read.
    logic signed [CS-1:0] coef [TAPS];
    assign coeff_data = coef[coeff_addr];

    // External MAC: product register, then accumulator with registered enable.
    logic signed [ACC_W-1:0] mult_q, acc_q;
    logic                    en_q;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mult_q <= '0;
            acc_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            if (mac_en) mult_q <= $signed(mac_s) * $signed(mac_c);
            en_q <= mac_en;
            if (en_q) acc_q <= acc_q + mult_q;
        end
    end
    assign mac_dout = acc_q;

    // Reference model: newest-first sample history, y = sum coef[k]*x[n-k].
    logic signed [SS-1:0] hist [TAPS];

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) hist[i] = '0;
    endfunction

    function automatic logic signed [ACC_W-1:0] model_push(input logic signed [SS-1:0] d);
        logic signed [ACC_W-1:0] sum;
        sum = '0;
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        for (int i = 0; i < TAPS; i++) sum = sum + ACC_W'(hist[i]) * ACC_W'(coef[i]);
        return sum;
    endfunction

    function automatic logic [YW-1:0] to_y(input logic signed [ACC_W-1:0] full);
`ifdef RACE_SEQ_SAT_EN
        logic signed [ACC_W-1:0] sh;
        sh = full >>> FS;
        if (sh > 33'sd32767) return 16'h7fff;
        if (sh < -33'sd32768) return 16'h8000;
        return sh[15:0];
`else
        return full;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [YW-1:0] y;
        int            acc_cyc;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    // Result monitor: data and accept-to-strobe latency (consuming edge = TAPS+3).
    always @(negedge clk) begin
        if (nrst && y_valid) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_y_valid: y_data=0x%0h with no outstanding sample", y_data);
            end else begin
                mon_e = expq.pop_front();
                check("y_data", 64'(y_data), 64'(mon_e.y));
                check("latency", 64'(cyc - mon_e.acc_cyc + 1), 64'(TAPS + 3));
            end
        end
    end

    // Present a sample at a negedge, hold until accepted; returns wait and accept cycle.
    task automatic send(input logic signed [SS-1:0] d, input bit use_tbl,
                        input logic [YW-1:0] tbl_y, output int waited, output int acc_at);
        exp_t e;
        logic [YW-1:0] m;
        waited  = 0;
        acc_at  = -1;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_ready_timeout: still 0 after %0d cycles", waited);
                s_valid = 1'b0;
                return;
            end
        end
        m        = to_y(model_push(d));
        e.y      = use_tbl ? tbl_y : m;
        e.acc_cyc = cyc + 1;
        acc_at   = e.acc_cyc;
        expq.push_back(e);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding", expq.size());
            expq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
        coef[0] = CS'(c0);
        coef[1] = CS'(c1);
        coef[2] = CS'(c2);
        coef[3] = CS'(c3);
    endtask

    typedef struct {
        logic signed [SS-1:0]    s;
        logic signed [ACC_W-1:0] y;
    } vec_t;
    vec_t imp_tbl  [4];
    vec_t step_tbl [4];

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int w, a, prev_a;

        imp_tbl[0]  = '{16'sd1, 33'sd1};
        imp_tbl[1]  = '{16'sd0, 33'sd2};
        imp_tbl[2]  = '{16'sd0, 33'sd3};
        imp_tbl[3]  = '{16'sd0, 33'sd4};
        step_tbl[0] = '{16'sd5, -33'sd5};
        step_tbl[1] = '{16'sd5, 33'sd5};
        step_tbl[2] = '{16'sd5, -33'sd10};
        step_tbl[3] = '{16'sd5, 33'sd10};

        nrst    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        set_coef(0, 0, 0, 0);
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_s_ready", 64'(s_ready), 64'(0));
        check("reset_mac_en", 64'(mac_en), 64'(0));
        check("reset_y_valid", 64'(y_valid), 64'(0));
        check("reset_y_data", 64'(y_data), 64'(0));
        nrst = 1'b1;
        @(negedge clk);
        check("s_ready_after_release", 64'(s_ready), 64'(1));

        // Impulse response
        set_coef(1, 2, 3, 4);
        for (int i = 0; i < 4; i++) send(imp_tbl[i].s, 1'b1, to_y(imp_tbl[i].y), w, a);
        drain();

        // Step with negative coefficients
        set_coef(-1, 2, -3, 4);
        for (int i = 0; i < 4; i++) send(step_tbl[i].s, 1'b1, to_y(step_tbl[i].y), w, a);
        drain();

        // Backpressure: s_valid stays high, accepts must be TAPS+4 apart
        prev_a = 0;
        for (int i = 0; i < 10; i++) begin
            send(SS'($urandom), 1'b0, '0, w, a);
            if (i > 0) begin
                check("bp_ready_low_cycles", 64'(w), 64'(TAPS + 3));
                check("bp_accept_spacing", 64'(a - prev_a), 64'(TAPS + 4));
            end
            prev_a = a;
        end
        drain();

        // Full-scale products until the accumulator wraps
        set_coef(65535, 1, 0, 0);
        for (int i = 0; i < 20; i++) send(16'sh7fff, 1'b0, '0, w, a);
        drain();

        // Reset during RUN at k=2; the aborted sample must leave no trace
        set_coef(1, 2, 3, 4);
        s_valid = 1'b1;
        s_data  = 16'sd77;
        while (!s_ready) @(negedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midburst_coeff_addr", 64'(coeff_addr), 64'(2));
        nrst = 1'b0;
        #1;
        check("midburst_reset_s_ready", 64'(s_ready), 64'(0));
        check("midburst_reset_mac_en", 64'(mac_en), 64'(0));
        check("midburst_reset_y_data", 64'(y_data), 64'(0));
        expq.delete();
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) send(imp_tbl[i].s, 1'b1, to_y(imp_tbl[i].y), w, a);
        drain();

`ifdef RACE_SEQ_SAT_EN
        // Saturation flag follows the most recent result
        set_coef(40000, 0, 0, 0);
        send(16'sd1, 1'b1, 16'h7fff, w, a);
        drain();
        check("sat_flag_set", 64'(dut.sat_flag_q), 64'(1));
        set_coef(10, 0, 0, 0);
        send(16'sd1, 1'b1, 16'd10, w, a);
        drain();
        check("sat_flag_clear", 64'(dut.sat_flag_q), 64'(0));
`endif

        // Random samples and coefficients against the reference model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < TAPS; i++) coef[i] = CS'(int'($urandom_range(65534, 0)) - 32767);
            for (int i = 0; i < 8; i++) send(SS'($urandom), 1'b0, '0, w, a);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
